// File: rtl/reg_file_swap.sv
// Register file with an in-place swap engine.
// One external write/async-read port plus a 4-cycle hardware swap of two words.
module reg_file_swap #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr_w,
    input  logic [DATA_WIDTH-1:0] data_w,
    input  logic [ADDR_WIDTH-1:0] addr_r,
    output logic [DATA_WIDTH-1:0] data_r,
    input  logic                  swap_start,
    input  logic [ADDR_WIDTH-1:0] swap_addr_a,
    input  logic [ADDR_WIDTH-1:0] swap_addr_b,
    output logic                  busy,
    output logic                  swap_done,
    output logic                  wr_reject,
    output logic [CNT_WIDTH-1:0]  swap_count
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WR_A,
        S_WR_B,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_addr_a;
    logic [ADDR_WIDTH-1:0] r_addr_b;
    logic [DATA_WIDTH-1:0] r_tmp_a;
    logic [DATA_WIDTH-1:0] r_tmp_b;
    logic                  r_wr_reject;
    logic [CNT_WIDTH-1:0]  r_count;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_mem_we;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [DATA_WIDTH-1:0] w_mem_data;

    // Single array write port, shared by the host (IDLE) and the swap engine.
    always_comb begin
        w_next     = r_state;
        w_mem_we   = 1'b0;
        w_mem_addr = addr_w;
        w_mem_data = data_w;
        unique case (r_state)
            S_IDLE: begin
                w_mem_we = we;
                if (swap_start) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                w_next = S_WR_A;
            end
            S_WR_A: begin
                w_mem_we   = 1'b1;
                w_mem_addr = r_addr_a;
                w_mem_data = r_tmp_b;
                w_next     = S_WR_B;
            end
            S_WR_B: begin
                w_mem_we   = 1'b1;
                w_mem_addr = r_addr_b;
                w_mem_data = r_tmp_a;
                w_next     = S_DONE;
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_addr_a    <= '0;
            r_addr_b    <= '0;
            r_tmp_a     <= '0;
            r_tmp_b     <= '0;
            r_wr_reject <= 1'b0;
            r_count     <= '0;
        end else begin
            r_state     <= w_next;
            r_wr_reject <= we && (r_state != S_IDLE);
            if (r_state == S_IDLE && swap_start) begin
                r_addr_a <= swap_addr_a;
                r_addr_b <= swap_addr_b;
            end
            if (r_state == S_LOAD) begin
                r_tmp_a <= r_mem[r_addr_a];
                r_tmp_b <= r_mem[r_addr_b];
            end
            if (r_state == S_WR_B) begin
                r_count <= r_count + CNT_WIDTH'(1);
            end
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_data;
        end
    end

    assign data_r     = r_mem[addr_r];
    assign busy       = (r_state != S_IDLE);
    assign swap_done  = (r_state == S_DONE);
    assign wr_reject  = r_wr_reject;
    assign swap_count = r_count;

endmodule

// File: tb/tb_reg_file_swap.sv
// Randomised bench for reg_file_swap against a timeline model of the swap,
// plus directed scenarios with literal expectations.
module tb_reg_file_swap;

    logic       clk;
    logic       rst_n;
    logic       we;
    logic [6:0] addr_w;
    logic [7:0] data_w;
    logic [6:0] addr_r;
    logic [7:0] data_r;
    logic       swap_start;
    logic [6:0] swap_addr_a;
    logic [6:0] swap_addr_b;
    logic       busy;
    logic       swap_done;
    logic       wr_reject;
    logic [7:0] swap_count;

    int n_pass = 0;
    int n_total = 0;

    reg_file_swap #(.ADDR_WIDTH(7), .DATA_WIDTH(8), .CNT_WIDTH(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .we(we),
        .addr_w(addr_w),
        .data_w(data_w),
        .addr_r(addr_r),
        .data_r(data_r),
        .swap_start(swap_start),
        .swap_addr_a(swap_addr_a),
        .swap_addr_b(swap_addr_b),
        .busy(busy),
        .swap_done(swap_done),
        .wr_reject(wr_reject),
        .swap_count(swap_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: memory contents plus "cycles since the swap was accepted".
    logic [7:0] mm [128];
    bit         mv [128];
    int         k = -1;
    int         mcnt = 0;
    bit         mrej = 1'b0;
    int         ma = 0;
    int         mb = 0;
    logic [7:0] va = 8'h00;
    logic [7:0] vb = 8'h00;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                k = -1;
                mcnt = 0;
                mrej = 1'b0;
            end else begin
                mrej = we && (k >= 0);
                if (k < 0) begin
                    if (we) begin
                        mm[addr_w] = data_w;
                        mv[addr_w] = 1'b1;
                    end
                    if (swap_start) begin
                        ma = int'(swap_addr_a);
                        mb = int'(swap_addr_b);
                        va = mm[ma];
                        vb = mm[mb];
                        k = 0;
                    end
                end else begin
                    k++;
                    if (k == 2) mm[ma] = vb;
                    else if (k == 3) begin
                        mm[mb] = va;
                        mcnt = (mcnt + 1) % 256;
                    end else if (k == 4) k = -1;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("busy", 32'(busy), 32'(k >= 0));
            chk("swap_done", 32'(swap_done), 32'(k == 3));
            chk("wr_reject", 32'(wr_reject), 32'(mrej));
            chk("swap_count", 32'(swap_count), 32'(mcnt));
            if (mv[addr_r]) chk("data_r", 32'(data_r), 32'(mm[addr_r]));
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int d);
        we = 1'b1;
        addr_w = 7'(a);
        data_w = 8'(d);
        step();
        we = 1'b0;
    endtask

    task automatic rd(input string nm, input int a, input int exp);
        addr_r = 7'(a);
        #1;
        chk(nm, 32'(data_r), 32'(exp));
    endtask

    task automatic run_swap(input int a, input int b,
                            output int nb, output int nd);
        swap_start = 1'b1;
        swap_addr_a = 7'(a);
        swap_addr_b = 7'(b);
        step();
        swap_start = 1'b0;
        we = 1'b0;
        nb = busy ? 1 : 0;
        nd = 0;
        for (int i = 0; i < 10 && busy; i++) begin
            step();
            if (busy) nb++;
            if (swap_done) nd++;
        end
    endtask

    initial begin
        int nb;
        int nd;
        int last;
        int badsp;
        rst_n = 1'b1;
        we = 1'b0;
        addr_w = '0;
        data_w = '0;
        addr_r = '0;
        swap_start = 1'b0;
        swap_addr_a = '0;
        swap_addr_b = '0;
        #2 rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(swap_done), 32'd0);
        chk("rst_rej", 32'(wr_reject), 32'd0);
        chk("rst_cnt", 32'(swap_count), 32'd0);

        for (int i = 0; i < 128; i++) wr(i, int'($urandom_range(0, 255)));

        // Basic swap
        wr(3, 8'h11);
        wr(9, 8'h22);
        run_swap(3, 9, nb, nd);
        chk("t1_busy_cycles", 32'(nb), 32'd4);
        chk("t1_done_pulses", 32'(nd), 32'd1);
        rd("t1_mem3", 3, 8'h22);
        rd("t1_mem9", 9, 8'h11);
        chk("t1_cnt", 32'(swap_count), 32'd1);

        // Self swap
        wr(7, 8'h5A);
        run_swap(7, 7, nb, nd);
        chk("t2_done_pulses", 32'(nd), 32'd1);
        rd("t2_mem7", 7, 8'h5A);
        chk("t2_cnt", 32'(swap_count), 32'd2);

        // Write while busy, re-issued start while busy
        wr(20, 8'h3C);
        swap_start = 1'b1;
        swap_addr_a = 7'd1;
        swap_addr_b = 7'd2;
        step();
        swap_addr_a = 7'd5;
        swap_addr_b = 7'd6;
        we = 1'b1;
        addr_w = 7'd20;
        data_w = 8'hFF;
        step();
        chk("t3_rej_on", 32'(wr_reject), 32'd1);
        we = 1'b0;
        swap_start = 1'b0;
        step();
        chk("t3_rej_off", 32'(wr_reject), 32'd0);
        for (int i = 0; i < 10 && busy; i++) step();
        step();
        step();
        chk("t3_idle", 32'(busy), 32'd0);
        chk("t3_cnt", 32'(swap_count), 32'd3);
        rd("t3_mem20", 20, 8'h3C);

        // Write and swap start in the same cycle
        wr(9, 8'h22);
        we = 1'b1;
        addr_w = 7'd3;
        data_w = 8'h77;
        run_swap(3, 9, nb, nd);
        rd("t4_mem3", 3, 8'h22);
        rd("t4_mem9", 9, 8'h77);
        chk("t4_cnt", 32'(swap_count), 32'd4);

        // Reset during WR_B
        wr(3, 8'h11);
        wr(9, 8'h22);
        swap_start = 1'b1;
        swap_addr_a = 7'd3;
        swap_addr_b = 7'd9;
        step();
        swap_start = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_done", 32'(swap_done), 32'd0);
        chk("t5_cnt", 32'(swap_count), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        rd("t5_mem3", 3, 8'h22);
        rd("t5_mem9", 9, 8'h22);

        // Back-to-back swaps, counter wrap
        nd = 0;
        last = -1;
        badsp = 0;
        swap_start = 1'b1;
        for (int cyc = 0; cyc < 2000 && nd < 256; cyc++) begin
            step();
            swap_addr_a = 7'($urandom);
            swap_addr_b = 7'($urandom);
            addr_r = 7'($urandom);
            if (swap_done) begin
                if (last >= 0 && cyc - last != 5) badsp++;
                last = cyc;
                nd++;
                if (nd == 128) chk("t6_cnt128", 32'(swap_count), 32'd128);
            end
        end
        swap_start = 1'b0;
        chk("t6_ndone", 32'(nd), 32'd256);
        chk("t6_cnt_wrap", 32'(swap_count), 32'd0);
        chk("t6_spacing", 32'(badsp), 32'd0);
        for (int i = 0; i < 6; i++) step();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            we = ($urandom_range(0, 1) == 1);
            addr_w = 7'($urandom);
            data_w = 8'($urandom);
            addr_r = 7'($urandom);
            swap_start = ($urandom_range(0, 4) == 0);
            swap_addr_a = 7'($urandom);
            swap_addr_b = ($urandom_range(0, 7) == 0) ? swap_addr_a
                                                       : 7'($urandom);
            step();
        end
        we = 1'b0;
        swap_start = 1'b0;
        for (int i = 0; i < 6; i++) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
